// File: rtl/branch_resolve_pkg.sv
// Shared types and constants for the EX-stage branch resolution slice.
package branch_resolve_pkg;

   localparam logic        BP_TAKEN       = 1'b1;
   localparam logic        BP_NO          = 1'b0;
   localparam logic [31:0] DELAY_SLOT_OFS = 32'd8;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } br_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic        taken;
      logic [31:0] target;
   } br_entry_t;

   // Fetch PC after a not-taken branch skips the delay slot; wraps at 32 bits.
   function automatic logic [31:0] fallthrough_pc(input logic [31:0] pc);
      return pc + DELAY_SLOT_OFS;
   endfunction

endpackage

// File: rtl/branch_resolve_fifo.sv
// In-order prediction queue (br_pred_fifo): circular buffer with push, pop and clear.
// Pointers carry one extra wrap bit so full/empty fall out of an MSB compare.
module br_pred_fifo
   import branch_resolve_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      clear,
   input  logic      push,
   input  logic      pop,
   input  br_entry_t din,
   output br_entry_t head,
   output logic      full,
   output logic      empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   br_entry_t       mem_r [DEPTH];
   logic [PW-1:0]   wr_ptr_r;
   logic [PW-1:0]   rd_ptr_r;
   logic            push_ok_s;
   logic            pop_ok_s;

   assign empty     = (wr_ptr_r == rd_ptr_r);
   assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   assign push_ok_s = push && (!full || pop);
   assign pop_ok_s  = pop && !empty;
   assign head      = mem_r[rd_ptr_r[AW-1:0]];

   // Pointer update; clear discards every outstanding entry.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
      end else if (clear) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
      end else begin
         if (push_ok_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
         if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
   end

   // Entry storage.
   always_ff @(posedge clk) begin
      if (push_ok_s && !clear) mem_r[wr_ptr_r[AW-1:0]] <= din;
   end

endmodule

// File: rtl/branch_resolve.sv
// Checks queued branch predictions against EX outcomes and drives flush/redirect/update.
// Optional BR_STATS_EN adds saturating resolution and mispredict counters.
module branch_resolve
   import branch_resolve_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int FLUSH_HOLD = 1,
   parameter int CNT_W      = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pred_valid,
   input  logic              pred_taken,
   input  logic [31:0]       pred_pc,
   input  logic [31:0]       pred_target,
   input  logic              res_valid,
   input  logic [31:0]       res_pc,
   input  logic              res_taken,
   input  logic [31:0]       res_target,
   output logic              flush,
   output logic [31:0]       redirect_pc,
   output logic              bp_update,
   output logic              q_full,
   output logic              q_empty,
   output logic              res_err
`ifdef BR_STATS_EN
   ,
   output logic [CNT_W-1:0]  stat_branches,
   output logic [CNT_W-1:0]  stat_mispred
`endif
);

   localparam int HW = $clog2(FLUSH_HOLD + 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(FLUSH_HOLD - 1);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

   br_state_e    state_r, state_nxt_s;
   logic         flush_r, flush_nxt_s;
   logic         bp_update_r, bp_update_nxt_s;
   logic [31:0]  redirect_r, redirect_nxt_s;
   logic [HW-1:0] hold_r, hold_nxt_s;
   logic         res_err_r, res_err_nxt_s;

   logic         push_s, pop_s, mispred_s;
   logic         full_s, empty_s;
   br_entry_t    head_s, din_s;

   assign din_s = '{pc: pred_pc, taken: pred_taken, target: pred_target};

   br_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (mispred_s),
      .push  (push_s),
      .pop   (pop_s),
      .din   (din_s),
      .head  (head_s),
      .full  (full_s),
      .empty (empty_s)
   );

   // Next-state and output decode; wrong-path traffic is ignored while flushing.
   always_comb begin
      state_nxt_s     = state_r;
      flush_nxt_s     = flush_r;
      bp_update_nxt_s = 1'b0;
      redirect_nxt_s  = redirect_r;
      hold_nxt_s      = hold_r;
      res_err_nxt_s   = res_err_r;
      push_s          = 1'b0;
      pop_s           = 1'b0;
      mispred_s       = 1'b0;
      case (state_r)
         ST_RUN: begin
            pop_s     = res_valid && !empty_s;
            mispred_s = pop_s && ((head_s.taken != res_taken) ||
                                  ((res_taken == BP_TAKEN) && (head_s.target != res_target)));
            push_s    = pred_valid && (!full_s || pop_s) && !mispred_s;
            if ((pred_valid && full_s && !pop_s) || (res_valid && empty_s) ||
                (pop_s && (res_pc != head_s.pc))) begin
               res_err_nxt_s = 1'b1;
            end else begin
               res_err_nxt_s = res_err_r;
            end
            if (mispred_s) begin
               state_nxt_s     = ST_FLUSH;
               flush_nxt_s     = 1'b1;
               bp_update_nxt_s = 1'b1;
               redirect_nxt_s  = (res_taken == BP_TAKEN) ? res_target : fallthrough_pc(res_pc);
               hold_nxt_s      = HOLD_INIT;
            end else begin
               flush_nxt_s     = 1'b0;
            end
         end
         ST_FLUSH: begin
            if (hold_r == {HW{1'b0}}) begin
               state_nxt_s = ST_RUN;
               flush_nxt_s = 1'b0;
            end else begin
               hold_nxt_s  = hold_r - HOLD_ONE;
            end
         end
         default: begin
            state_nxt_s = ST_RUN;
            flush_nxt_s = 1'b0;
         end
      endcase
   end

   // State and registered-output update.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= ST_RUN;
         flush_r     <= 1'b0;
         bp_update_r <= 1'b0;
         redirect_r  <= 32'd0;
         hold_r      <= {HW{1'b0}};
         res_err_r   <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         flush_r     <= flush_nxt_s;
         bp_update_r <= bp_update_nxt_s;
         redirect_r  <= redirect_nxt_s;
         hold_r      <= hold_nxt_s;
         res_err_r   <= res_err_nxt_s;
      end
   end

   assign flush       = flush_r;
   assign bp_update   = bp_update_r;
   assign redirect_pc = redirect_r;
   assign res_err     = res_err_r;
   assign q_full      = full_s;
   assign q_empty     = empty_s;

`ifdef BR_STATS_EN
   logic [CNT_W-1:0] stat_br_r, stat_mp_r;

   // Saturating statistics counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stat_br_r <= {CNT_W{1'b0}};
         stat_mp_r <= {CNT_W{1'b0}};
      end else begin
         if (pop_s && (stat_br_r != {CNT_W{1'b1}}))     stat_br_r <= stat_br_r + CNT_W'(1);
         if (mispred_s && (stat_mp_r != {CNT_W{1'b1}})) stat_mp_r <= stat_mp_r + CNT_W'(1);
      end
   end

   assign stat_branches = stat_br_r;
   assign stat_mispred  = stat_mp_r;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve (DEPTH=4, FLUSH_HOLD=3).
module tb_branch_resolve;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        pred_valid = 1'b0, pred_taken = 1'b0;
   logic [31:0] pred_pc = 32'd0, pred_target = 32'd0;
   logic        res_valid = 1'b0, res_taken = 1'b0;
   logic [31:0] res_pc = 32'd0, res_target = 32'd0;
   logic        flush, bp_update, q_full, q_empty, res_err;
   logic [31:0] redirect_pc;
`ifdef BR_STATS_EN
   logic [31:0] stat_branches, stat_mispred;
`endif
   int total = 0;
   int bad   = 0;

   branch_resolve #(.DEPTH(4), .FLUSH_HOLD(3), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_pc(pred_pc), .pred_target(pred_target),
      .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
      .flush(flush), .redirect_pc(redirect_pc), .bp_update(bp_update),
      .q_full(q_full), .q_empty(q_empty), .res_err(res_err)
`ifdef BR_STATS_EN
      , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_one(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      pred_valid = 1'b1; pred_pc = pc; pred_taken = tk; pred_target = tgt;
      tick();
      pred_valid = 1'b0;
   endtask

   task automatic resolve(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
      res_valid = 1'b1; res_pc = pc; res_taken = tk; res_target = tgt;
      tick();
      res_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      rst = 1'b1;
   endtask

`ifdef BR_STATS_EN
   task automatic do_branch(input logic [31:0] pc, input logic ptk, input logic rtk);
      push_one(pc, ptk, pc + 32'h40);
      resolve(pc, rtk, pc + 32'h40);
      if (ptk != rtk) repeat (3) tick();
   endtask
`endif

   initial begin
      // reset state
      tick(); tick();
      chk("rst_flush", flush, 1'b0);
      chk("rst_bp", bp_update, 1'b0);
      chk("rst_redir", redirect_pc, 32'd0);
      chk("rst_err", res_err, 1'b0);
      chk("rst_empty", q_empty, 1'b1);
      chk("rst_full", q_full, 1'b0);
      rst = 1'b1;
      tick();

      // 1: correct taken prediction
      push_one(32'h100, 1'b1, 32'h140);
      chk("t1_notempty", q_empty, 1'b0);
      resolve(32'h100, 1'b1, 32'h140);
      chk("t1_flush", flush, 1'b0);
      chk("t1_empty", q_empty, 1'b1);
      chk("t1_err", res_err, 1'b0);

      // 2: predicted not-taken, actually taken
      push_one(32'h200, 1'b0, 32'h260);
      resolve(32'h200, 1'b1, 32'h260);
      chk("t2_flush", flush, 1'b1);
      chk("t2_bp", bp_update, 1'b1);
      chk("t2_redir", redirect_pc, 32'h260);
      tick();
      chk("t2_flush2", flush, 1'b1);
      chk("t2_bp2", bp_update, 1'b0);
      tick();
      chk("t2_flush3", flush, 1'b1);
      tick();
      chk("t2_flush_end", flush, 1'b0);

      // 3: predicted taken, actually not-taken; second entry is cleared, FLUSH ignores pushes
      push_one(32'h300, 1'b1, 32'h340);
      push_one(32'h304, 1'b0, 32'h380);
      resolve(32'h300, 1'b0, 32'h340);
      chk("t3_flush", flush, 1'b1);
      chk("t3_redir", redirect_pc, 32'h308);
      chk("t3_cleared", q_empty, 1'b1);
      pred_valid = 1'b1; pred_pc = 32'h30c; pred_taken = 1'b0;
      tick(); tick();
      chk("t3_flush3", flush, 1'b1);
      pred_valid = 1'b0;
      tick();
      chk("t3_flush_end", flush, 1'b0);
      chk("t3_ignored_push", q_empty, 1'b1);

      // 4: fill, overflow, push+pop while full, drain
      push_one(32'h400, 1'b0, 32'h500);
      push_one(32'h404, 1'b0, 32'h500);
      push_one(32'h408, 1'b0, 32'h500);
      chk("t4_not_full3", q_full, 1'b0);
      push_one(32'h40c, 1'b0, 32'h500);
      chk("t4_full", q_full, 1'b1);
      chk("t4_err_clean", res_err, 1'b0);
      push_one(32'h410, 1'b0, 32'h500);
      chk("t4_overflow_err", res_err, 1'b1);
      chk("t4_still_full", q_full, 1'b1);
      pred_valid = 1'b1; pred_pc = 32'h414; pred_taken = 1'b0; pred_target = 32'h500;
      resolve(32'h400, 1'b0, 32'h0);
      pred_valid = 1'b0;
      chk("t4_pushpop_full", q_full, 1'b1);
      chk("t4_pushpop_flush", flush, 1'b0);
      resolve(32'h404, 1'b0, 32'h0);
      resolve(32'h408, 1'b0, 32'h0);
      resolve(32'h40c, 1'b0, 32'h0);
      resolve(32'h414, 1'b0, 32'h0);
      chk("t4_drained", q_empty, 1'b1);
      chk("t4_drain_flush", flush, 1'b0);
      chk("t4_sticky", res_err, 1'b1);

      // 5: resolve on empty, push+pop on empty, mispredict with simultaneous push
      do_reset();
      chk("t5_err_reset", res_err, 1'b0);
      resolve(32'h500, 1'b0, 32'h0);
      chk("t5_empty_err", res_err, 1'b1);
      chk("t5_no_flush", flush, 1'b0);
      pred_valid = 1'b1; pred_pc = 32'h500; pred_taken = 1'b0; pred_target = 32'h600;
      resolve(32'h500, 1'b0, 32'h0);
      pred_valid = 1'b0;
      chk("t5_push_kept", q_empty, 1'b0);
      pred_valid = 1'b1; pred_pc = 32'h504; pred_taken = 1'b0; pred_target = 32'h700;
      resolve(32'h500, 1'b1, 32'h600);
      pred_valid = 1'b0;
      chk("t5_flush", flush, 1'b1);
      chk("t5_redir", redirect_pc, 32'h600);
      chk("t5_push_discard", q_empty, 1'b1);
      repeat (3) tick();
      chk("t5_flush_end", flush, 1'b0);

`ifdef BR_STATS_EN
      // 6: statistics, 10 resolutions with 3 mispredicts
      do_reset();
      do_branch(32'h1000, 1'b1, 1'b1);
      do_branch(32'h1004, 1'b0, 1'b1);
      do_branch(32'h1008, 1'b0, 1'b0);
      do_branch(32'h100c, 1'b1, 1'b1);
      do_branch(32'h1010, 1'b1, 1'b0);
      do_branch(32'h1014, 1'b0, 1'b0);
      do_branch(32'h1018, 1'b0, 1'b0);
      do_branch(32'h101c, 1'b1, 1'b1);
      do_branch(32'h1020, 1'b0, 1'b1);
      do_branch(32'h1024, 1'b1, 1'b1);
      chk("t6_branches", stat_branches, 32'd10);
      chk("t6_mispred", stat_mispred, 32'd3);
`endif

      // pc mismatch still resolves; redirect wraps at 32 bits; reset mid-FLUSH
      do_reset();
      push_one(32'h700, 1'b0, 32'h800);
      resolve(32'h704, 1'b0, 32'h0);
      chk("pcmis_err", res_err, 1'b1);
      chk("pcmis_flush", flush, 1'b0);
      chk("pcmis_popped", q_empty, 1'b1);
      push_one(32'hFFFF_FFFC, 1'b1, 32'h80);
      resolve(32'hFFFF_FFFC, 1'b0, 32'h0);
      chk("wrap_redir", redirect_pc, 32'h4);
      tick();
      chk("mid_flush", flush, 1'b1);
      rst = 1'b0;
      #1;
      chk("arst_flush", flush, 1'b0);
      chk("arst_bp", bp_update, 1'b0);
      chk("arst_redir", redirect_pc, 32'd0);
      chk("arst_err", res_err, 1'b0);
      chk("arst_empty", q_empty, 1'b1);
      chk("arst_full", q_full, 1'b0);
`ifdef BR_STATS_EN
      chk("arst_stat_br", stat_branches, 32'd0);
      chk("arst_stat_mp", stat_mispred, 32'd0);
`endif
      tick();
      rst = 1'b1;
      tick();
      chk("post_rst_flush", flush, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
